scc_mem_responder: RTL and testbench

Unified instruction/data memory responder for the SCC core. It answers the core's instruction-fetch port (`in_mem_addr`/`in_mem_en` → `in_mem`) and its data port (`data_addr`/`data_out`/`data_read`/`data_write` → `data_in`) from a single word array with registered reads. A byte-serial loader preloads program images while the core is held off via `load_busy`. It sits beside the core at SoC top level, and its ports mirror the core's memory interface names.

---
 rtl/scc_mem_responder_if.sv | 39 +++
 rtl/scc_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_scc_mem_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scc_mem_responder_if.sv
// Core-side and loader-side signal bundle for the SCC memory responder.
// master = core and image loader driving requests, slave = the responder.
interface scc_mem_responder_if #(
  parameter int AW = 10
);
  logic [31:0] in_mem_addr;
  logic        in_mem_en;
  logic [31:0] in_mem;

  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_in;

  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;
  logic [AW:0] load_count;
  logic        access_err;

  modport master (
    output in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write,
           load_start, load_valid, load_byte, load_last,
    input  in_mem, data_in, load_ready, load_busy, load_done, load_count,
           access_err
  );

  modport slave (
    input  in_mem_addr, in_mem_en, data_addr, data_out, data_read, data_write,
           load_start, load_valid, load_byte, load_last,
    output in_mem, data_in, load_ready, load_busy, load_done, load_count,
           access_err
  );
endinterface

// File: rtl/scc_mem_responder.sv
// Unified instruction/data word memory with registered read-first ports and a
// byte-serial image loader that holds the core off while it runs.
module scc_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             reset,
  scc_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } load_state_e;

  // NOTE: the memory array has no reset; contents are undefined until written.
  logic [31:0] mem [DEPTH];

  load_state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          last_q, last_d;
  logic [AW:0]   count_q, count_d;
  logic          done_q, done_d;
  logic [31:0]   in_mem_q, in_mem_d;
  logic [31:0]   data_in_q, data_in_d;
  logic          err_q, err_d;

  logic          busy;
  logic          i_bad, d_bad;
  logic [AW-1:0] i_idx, d_idx;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  function automatic logic is_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
  endfunction

  assign busy  = (state_q != IDLE);
  assign i_bad = is_bad(bus.in_mem_addr);
  assign d_bad = is_bad(bus.data_addr);
  assign i_idx = bus.in_mem_addr[AW+1:2];
  assign d_idx = bus.data_addr[AW+1:2];

  // Loader next-state logic
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    last_d     = last_q;
    count_d    = count_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          ptr_d      = '0;
          byte_cnt_d = '0;
          count_d    = '0;
          shift_d    = '0;
          last_d     = 1'b0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.load_valid) begin
          shift_d[{byte_cnt_q, 3'b000} +: 8] = bus.load_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3 || bus.load_last) begin
            last_d  = bus.load_last;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        ptr_d      = ptr_q + AW'(1);
        count_d    = count_q + (AW+1)'(1);
        shift_d    = '0;
        byte_cnt_d = '0;
        // Stop on the tagged last byte or when the final word slot is filled.
        if (last_q || (&ptr_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core ports: busy forces zeros and masks writes and fault reporting.
  always_comb begin
    in_mem_d  = in_mem_q;
    data_in_d = data_in_q;
    err_d     = err_q;
    if (busy) begin
      in_mem_d = '0;
    end else if (bus.in_mem_en) begin
      in_mem_d = i_bad ? '0 : mem[i_idx];
    end
    if (bus.data_read) begin
      data_in_d = (busy || d_bad) ? '0 : mem[d_idx];
    end
    if (!busy) begin
      err_d = err_q | (bus.in_mem_en & i_bad)
                    | ((bus.data_read | bus.data_write) & d_bad);
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = d_idx;
    mem_wdata = bus.data_out;
    if (state_q == COMMIT) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = shift_q;
    end else if (!busy && bus.data_write && !d_bad) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values, which is also what makes the reads read-first.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      in_mem_q   <= '0;
      data_in_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      count_q    <= count_d;
      done_q     <= done_d;
      in_mem_q   <= in_mem_d;
      data_in_q  <= data_in_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_mem     = in_mem_q;
  assign bus.data_in    = data_in_q;
  assign bus.load_ready = (state_q == COLLECT);
  assign bus.load_busy  = busy;
  assign bus.load_done  = done_q;
  assign bus.load_count = count_q;
  assign bus.access_err = err_q;

endmodule

// File: tb/tb_scc_mem_responder.sv
// Directed bench for scc_mem_responder: data/fetch ports, fault flag, loader
// handshake, reset during a load and a full-depth image.
module tb_scc_mem_responder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  scc_mem_responder_if #(.AW(AW)) bus ();

  scc_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.in_mem_addr = '0;
    bus.in_mem_en   = 1'b0;
    bus.data_addr   = '0;
    bus.data_out    = '0;
    bus.data_read   = 1'b0;
    bus.data_write  = 1'b0;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_byte   = '0;
    bus.load_last   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.in_mem_addr = a;
    bus.in_mem_en   = 1'b1;
    step();
    bus.in_mem_en   = 1'b0;
  endtask

  task automatic dread(input logic [31:0] a);
    bus.data_addr = a;
    bus.data_read = 1'b1;
    step();
    bus.data_read = 1'b0;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d);
    bus.data_addr  = a;
    bus.data_out   = d;
    bus.data_write = 1'b1;
    step();
    bus.data_write = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    bus.load_last  = last;
    while (!bus.load_ready && n < 8) begin
      step();
      n++;
    end
    check("ready_wait", 32'(bus.load_ready), 32'd1);
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  initial begin
    idle_bus();
    step();
    step();
    check("rst_in_mem",  bus.in_mem, 32'h0);
    check("rst_data_in", bus.data_in, 32'h0);
    check("rst_ready",   32'(bus.load_ready), 32'd0);
    check("rst_busy",    32'(bus.load_busy), 32'd0);
    check("rst_done",    32'(bus.load_done), 32'd0);
    check("rst_count",   32'(bus.load_count), 32'd0);
    check("rst_err",     32'(bus.access_err), 32'd0);
    reset = 1'b1;
    step();

    // Write then read back
    dwrite(32'h10, 32'hDEADBEEF);
    dread(32'h10);
    check("wr_rd_10", bus.data_in, 32'hDEADBEEF);

    // Same-cycle write and read returns the old word
    dwrite(32'h20, 32'h5);
    bus.data_addr  = 32'h20;
    bus.data_out   = 32'h1;
    bus.data_write = 1'b1;
    bus.data_read  = 1'b1;
    step();
    bus.data_write = 1'b0;
    bus.data_read  = 1'b0;
    check("rd_first", bus.data_in, 32'h5);
    dread(32'h20);
    check("rd_after", bus.data_in, 32'h1);
    bus.data_addr = 32'h10;
    step();
    check("data_hold", bus.data_in, 32'h1);

    // Instruction port
    fetch(32'h10);
    check("fetch_10", bus.in_mem, 32'hDEADBEEF);
    check("err_clean", 32'(bus.access_err), 32'd0);
    bus.in_mem_addr = 32'h20;
    step();
    check("fetch_hold", bus.in_mem, 32'hDEADBEEF);
    fetch(32'h3);
    check("fetch_misal", bus.in_mem, 32'h0);
    check("err_misal", 32'(bus.access_err), 32'd1);
    fetch(32'(4 * DEPTH));
    check("fetch_oor", bus.in_mem, 32'h0);
    check("err_oor", 32'(bus.access_err), 32'd1);
    fetch(32'h20);
    check("fetch_good", bus.in_mem, 32'h1);
    check("err_sticky", 32'(bus.access_err), 32'd1);

    // Five-byte image with load_last on the fifth byte
    pulse_start();
    check("ld_busy", 32'(bus.load_busy), 32'd1);
    check("ld_ready", 32'(bus.load_ready), 32'd1);
    check("ld_cnt0", 32'(bus.load_count), 32'd0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    check("commit_ready", 32'(bus.load_ready), 32'd0);
    check("busy_in_mem", bus.in_mem, 32'h0);
    step();
    check("ld_cnt1", 32'(bus.load_count), 32'd1);
    bus.data_addr   = 32'h0;
    bus.data_out    = 32'hFFFFFFFF;
    bus.data_write  = 1'b1;
    bus.data_read   = 1'b1;
    bus.in_mem_addr = 32'h10;
    bus.in_mem_en   = 1'b1;
    send_byte(8'hAA, 1'b1);
    bus.data_write  = 1'b0;
    bus.data_read   = 1'b0;
    bus.in_mem_en   = 1'b0;
    check("busy_fetch0", bus.in_mem, 32'h0);
    check("busy_read0", bus.data_in, 32'h0);
    check("done_early", 32'(bus.load_done), 32'd0);
    step();
    check("done_pulse", 32'(bus.load_done), 32'd1);
    check("done_idle", 32'(bus.load_busy), 32'd0);
    check("ld_cnt2", 32'(bus.load_count), 32'd2);
    step();
    check("done_clear", 32'(bus.load_done), 32'd0);
    check("ld_cnt2_hold", 32'(bus.load_count), 32'd2);
    fetch(32'h0);
    check("img_w0", bus.in_mem, 32'h12345678);
    fetch(32'h4);
    check("img_w1", bus.in_mem, 32'h000000AA);
    dread(32'h10);
    check("img_keep10", bus.data_in, 32'hDEADBEEF);

    // Reset in the middle of the second word
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    step();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.load_busy), 32'd0);
    check("mid_rst_ready", 32'(bus.load_ready), 32'd0);
    check("mid_rst_count", 32'(bus.load_count), 32'd0);
    check("mid_rst_err", 32'(bus.access_err), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_busy", 32'(bus.load_busy), 32'd0);
    fetch(32'h0);
    check("kept_w0", bus.in_mem, 32'h44332211);
    fetch(32'h4);
    check("no_w1", bus.in_mem, 32'h000000AA);

    // Bad data accesses
    dwrite(32'h22, 32'h99);
    check("err_bad_wr", 32'(bus.access_err), 32'd1);
    dread(32'h20);
    check("bad_wr_drop", bus.data_in, 32'h1);
    dread(32'h21);
    check("bad_rd_zero", bus.data_in, 32'h0);

    // Full-depth image without load_last; a stray start mid-load is ignored
    pulse_start();
    for (int w = 0; w < DEPTH; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (w == 8 && b == 0) bus.load_start = 1'b1;
        send_byte(8'(w * 16 + b), 1'b0);
        bus.load_start = 1'b0;
      end
    end
    check("full_busy", 32'(bus.load_busy), 32'd1);
    step();
    check("full_done", 32'(bus.load_done), 32'd1);
    check("full_idle", 32'(bus.load_busy), 32'd0);
    check("full_count", 32'(bus.load_count), 32'(DEPTH));
    fetch(32'h0);
    check("full_w0", bus.in_mem, 32'h03020100);
    fetch(32'h20);
    check("full_w8", bus.in_mem, 32'h83828180);
    fetch(32'(4 * (DEPTH - 1)));
    check("full_wlast", bus.in_mem, 32'hF3F2F1F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
